em4100_decoder: RTL and testbench

//   Receive side of the EM4100 path: recovers bits from a Manchester-coded tag stream (as

---
 rtl/em4100_decoder.sv | 185 ++++++++++++++++++
 tb/tb_em4100_decoder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/em4100_decoder.sv
// em4100_decoder: Manchester bit recovery, 64-bit EM4100 frame search, row/column parity check, ID output.
// Latency: 2-flop din sync + 1 edge-detect cycle to the bit shift; id_valid/frame_err 1 cycle after that shift.
// Backpressure: none; the ID register and the one-cycle pulses are produced unconditionally.
// Ports: clk/rst (async active-high); din raw Manchester input; id last accepted ID (id[39:36] first
//        nibble sent); id_valid / frame_err / manch_err one-cycle pulses; rx_active high while locked.
// Option: EM4100_DEC_DOUBLE_READ_EN - id only updates after two consecutive identical good frames.
module em4100_decoder #(
    parameter int HALF_BIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [39:0] id,
    output logic        id_valid,
    output logic        frame_err,
    output logic        manch_err,
    output logic        rx_active
);

    localparam int EARLY = 3 * HALF_BIT / 2;
    localparam int LATE  = 5 * HALF_BIT / 2;
    localparam int TW    = $clog2(LATE + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EARLY,
        WAIT_EDGE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [TW-1:0]  timer;
    logic [TW-1:0]  timer_nxt;

    logic           din_s1;
    logic           din_s2;
    logic           din_s3;
    logic           edge_det;

    logic [63:0]    sr;
    logic [6:0]     bit_cnt;
    logic           shift;
    logic           timeout;
    logic           chk;

    logic           hdr_ok;
    logic           stop_ok;
    logic           par_ok;
    logic [3:0]     col;
    logic [39:0]    id_frame;

`ifdef EM4100_DEC_DOUBLE_READ_EN
    logic [39:0]    cand;
    logic           cand_vld;
`endif

    assign edge_det  = din_s2 ^ din_s3;
    assign rx_active = (state != IDLE);

    // Bit recovery: only edges landing in [EARLY, LATE] after the previous
    // mid-bit edge count; bit-boundary edges fall inside WAIT_EARLY and are ignored.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        shift     = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (edge_det) begin
                    state_nxt = WAIT_EARLY;
                    timer_nxt = '0;
                end
            end
            WAIT_EARLY: begin
                timer_nxt = timer + 1'b1;
                if (timer == TW'(EARLY - 1)) begin
                    state_nxt = WAIT_EDGE;
                end
            end
            WAIT_EDGE: begin
                if (edge_det) begin
                    shift     = 1'b1;
                    timer_nxt = '0;
                    state_nxt = WAIT_EARLY;
                end else if (timer == TW'(LATE)) begin
                    timeout   = 1'b1;
                    timer_nxt = '0;
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    // Frame view of the shift register: sr[63:55] header, ten 5-bit rows
    // (nibble + even parity), sr[4:1] column parity, sr[0] stop.
    always_comb begin
        hdr_ok   = &sr[63:55];
        stop_ok  = ~sr[0];
        par_ok   = 1'b1;
        col      = sr[4:1];
        id_frame = '0;
        for (int i = 0; i < 10; i++) begin
            id_frame[39-4*i -: 4] = sr[54-5*i -: 4];
            if (^sr[54-5*i -: 5]) begin
                par_ok = 1'b0;
            end
            col = col ^ sr[54-5*i -: 4];
        end
        if (col != 4'd0) begin
            par_ok = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_s1    <= 1'b0;
            din_s2    <= 1'b0;
            din_s3    <= 1'b0;
            state     <= IDLE;
            timer     <= '0;
            sr        <= '0;
            bit_cnt   <= '0;
            chk       <= 1'b0;
            id        <= '0;
            id_valid  <= 1'b0;
            frame_err <= 1'b0;
            manch_err <= 1'b0;
`ifdef EM4100_DEC_DOUBLE_READ_EN
            cand      <= '0;
            cand_vld  <= 1'b0;
`endif
        end else begin
            din_s1    <= din;
            din_s2    <= din_s1;
            din_s3    <= din_s2;
            state     <= state_nxt;
            timer     <= timer_nxt;
            chk       <= shift;
            id_valid  <= 1'b0;
            frame_err <= 1'b0;
            manch_err <= 1'b0;

            if (shift) begin
                // Bit value is the inverse of the level after the mid-bit edge.
                sr <= {sr[62:0], ~din_s2};
                if (bit_cnt != 7'd64) begin
                    bit_cnt <= bit_cnt + 7'd1;
                end
            end else if (timeout) begin
                manch_err <= 1'b1;
                bit_cnt   <= '0;
`ifdef EM4100_DEC_DOUBLE_READ_EN
                cand_vld  <= 1'b0;
`endif
            end else if (chk && (bit_cnt == 7'd64) && hdr_ok && stop_ok) begin
                if (par_ok) begin
                    bit_cnt <= '0;
`ifdef EM4100_DEC_DOUBLE_READ_EN
                    if (cand_vld && (cand == id_frame)) begin
                        id       <= id_frame;
                        id_valid <= 1'b1;
                        cand_vld <= 1'b0;
                    end else begin
                        cand     <= id_frame;
                        cand_vld <= 1'b1;
                    end
`else
                    id       <= id_frame;
                    id_valid <= 1'b1;
`endif
                end else begin
                    // Keep bit_cnt at 64 so the window keeps sliding toward the next header.
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_em4100_decoder.sv
module tb_em4100_decoder;

    localparam int HALF_BIT = 16;
    localparam int LATE     = 5 * HALF_BIT / 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic [39:0] id;
    logic        id_valid;
    logic        frame_err;
    logic        manch_err;
    logic        rx_active;

    em4100_decoder #(.HALF_BIT(HALF_BIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .id        (id),
        .id_valid  (id_valid),
        .frame_err (frame_err),
        .manch_err (manch_err),
        .rx_active (rx_active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state: transmit bit stream, expected ID pulses, current ID.
    logic        tx_bits[$];
    logic [39:0] expq[$];
    logic [39:0] model_id = '0;
    logic [39:0] fids[$];
    int          fflip[$];
`ifdef EM4100_DEC_DOUBLE_READ_EN
    logic [39:0] cand = '0;
    bit          cand_vld = 1'b0;
`endif

    int cyc       = 0;
    int last_edge = 0;
    int last_merr = 0;
    int tot_valid = 0;
    int tot_ferr  = 0;
    int tot_merr  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: every id_valid must match the next expected ID in order.
    always @(negedge clk) begin
        if (!rst) begin
            if (id_valid) begin
                tot_valid++;
                if (expq.size() > 0) check("id_value", 64'(id), 64'(expq.pop_front()));
                else                 check("spurious_id_valid", 64'(id_valid), 64'(0));
            end
            if (frame_err) tot_ferr++;
            if (manch_err) begin
                tot_merr++;
                last_merr = cyc;
            end
            if (id_valid || frame_err || manch_err)
                check("pulse_overlap", 64'(int'(id_valid) + int'(frame_err) + int'(manch_err)), 64'(1));
        end
    end

    // EM4100 frame in transmit order: 9x'1', 10 rows of nibble(MSB first)+even parity,
    // 4 column parity bits, stop '0'. flip >= 0 inverts data bit number flip (0 = first sent).
    task automatic add_frame(input logic [39:0] v, input int flip);
        logic [3:0] nib;
        logic [3:0] col;
        int         start;
        int         pos;
        start = tx_bits.size();
        col   = '0;
        repeat (9) tx_bits.push_back(1'b1);
        for (int r = 0; r < 10; r++) begin
            nib = v[39-4*r -: 4];
            col = col ^ nib;
            for (int k = 3; k >= 0; k--) tx_bits.push_back(nib[k]);
            tx_bits.push_back(^nib);
        end
        for (int k = 3; k >= 0; k--) tx_bits.push_back(col[k]);
        tx_bits.push_back(1'b0);
        if (flip >= 0) begin
            pos = start + 9 + 5 * (flip / 4) + (flip % 4);
            tx_bits[pos] = !tx_bits[pos];
        end
    endtask

    task automatic model_good(input logic [39:0] v);
`ifdef EM4100_DEC_DOUBLE_READ_EN
        if (cand_vld && cand == v) begin
            expq.push_back(v);
            model_id = v;
            cand_vld = 1'b0;
        end else begin
            cand     = v;
            cand_vld = 1'b1;
        end
`else
        expq.push_back(v);
        model_id = v;
`endif
    endtask

    task automatic model_clear();
`ifdef EM4100_DEC_DOUBLE_READ_EN
        cand_vld = 1'b0;
`endif
    endtask

    // Manchester encoder: bit b = level b then level !b. Edge k (start of half k) is
    // displaced by j[k]: mid-bit edges -3..+4, bit boundaries -4..+4 clocks.
    // Stops before half abort_half when abort_half >= 0. Called at a negedge.
    task automatic play(input int abort_half, input bit jit);
        logic lv[$];
        int   j[$];
        int   n;
        n = tx_bits.size();
        for (int b = 0; b < n; b++) begin
            lv.push_back(tx_bits[b]);
            lv.push_back(!tx_bits[b]);
        end
        tx_bits.delete();
        for (int k = 0; k <= 2 * n; k++) begin
            if (jit && k > 0 && k < 2 * n)
                j.push_back((k % 2) ? int'($urandom_range(7, 0)) - 3 : int'($urandom_range(8, 0)) - 4);
            else
                j.push_back(0);
        end
        for (int k = 0; k < 2 * n; k++) begin
            if (abort_half >= 0 && k == abort_half) return;
            if (din != lv[k]) last_edge = cyc;
            din = lv[k];
            repeat (HALF_BIT + j[k+1] - j[k]) @(negedge clk);
        end
    endtask

    // One burst: preamble '0' (puts the decoder in mid-bit phase), the frames in
    // fids/fflip, a trailing '1' so din rests low, then idle until the timeout fires.
    task automatic run_burst(input string name, input bit jit);
        int b_valid;
        int b_ferr;
        int b_merr;
        int exp_valid;
        int exp_ferr;
        int delta;
        b_valid  = tot_valid;
        b_ferr   = tot_ferr;
        b_merr   = tot_merr;
        exp_ferr = 0;
        tx_bits.push_back(1'b0);
        for (int f = 0; f < fids.size(); f++) begin
            add_frame(fids[f], fflip[f]);
            if (fflip[f] < 0) model_good(fids[f]);
            else              exp_ferr++;
        end
        tx_bits.push_back(1'b1);
        exp_valid = expq.size();
        play(-1, jit);
        repeat (4 * HALF_BIT) @(negedge clk);
        model_clear();
        delta = last_merr - last_edge;
        check({name, ".id_valid_cnt"},  64'(tot_valid - b_valid), 64'(exp_valid));
        check({name, ".frame_err_cnt"}, 64'(tot_ferr - b_ferr),   64'(exp_ferr));
        check({name, ".manch_err_cnt"}, 64'(tot_merr - b_merr),   64'(1));
        check({name, ".manch_timing"},  64'(delta >= LATE + 2 && delta <= LATE + 6), 64'(1));
        check({name, ".id_hold"},       64'(id), 64'(model_id));
        check({name, ".rx_idle"},       64'(rx_active), 64'(0));
        fids.delete();
        fflip.delete();
    endtask

    initial begin
        logic [39:0] r;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset.id",        64'(id),        64'(0));
        check("reset.id_valid",  64'(id_valid),  64'(0));
        check("reset.frame_err", 64'(frame_err), 64'(0));
        check("reset.manch_err", 64'(manch_err), 64'(0));
        check("reset.rx_active", 64'(rx_active), 64'(0));
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Continuous frames of one ID
        repeat (4) begin fids.push_back(40'h123456789A); fflip.push_back(-1); end
        run_burst("cont", 1'b0);

        // Single flipped data bit: frame_err only, id holds
        fids.push_back(40'hCAFEBABE12); fflip.push_back(13);
        run_burst("flip", 1'b0);

        // Bad frame between good ones: window keeps sliding and relocks
        fids.push_back(40'h0055AA33CC); fflip.push_back(-1);
        fids.push_back(40'h0055AA33CC); fflip.push_back(0);
        fids.push_back(40'h0055AA33CC); fflip.push_back(-1);
        run_burst("slide", 1'b0);

        // Jittered edges, random IDs
        for (int b = 0; b < 2; b++) begin
            for (int f = 0; f < 3; f++) begin
                r = {8'($urandom), 32'($urandom)};
                fids.push_back(r); fflip.push_back(-1);
                fids.push_back(r); fflip.push_back(-1);
            end
            run_burst("jitter", 1'b1);
        end

        // Reset in the middle of a frame
        tx_bits.push_back(1'b0);
        add_frame(40'h0F1E2D3C4B, -1);
        play(2 * 31, 1'b0);
        check("rst.pre_active", 64'(rx_active), 64'(1));
        rst = 1'b1;
        din = 1'b0;
        #1;
        check("rst.id",        64'(id),        64'(0));
        check("rst.id_valid",  64'(id_valid),  64'(0));
        check("rst.frame_err", 64'(frame_err), 64'(0));
        check("rst.manch_err", 64'(manch_err), 64'(0));
        check("rst.rx_active", 64'(rx_active), 64'(0));
        model_id = '0;
        model_clear();
        @(negedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        fids.push_back(40'h0F1E2D3C4B); fflip.push_back(-1);
        fids.push_back(40'h0F1E2D3C4B); fflip.push_back(-1);
        run_burst("post_rst", 1'b0);

        // Alternating IDs (no confirmation ever happens in double-read builds)
        fids.push_back(40'hA1A2A3A4A5); fflip.push_back(-1);
        fids.push_back(40'hB1B2B3B4B5); fflip.push_back(-1);
        fids.push_back(40'hA1A2A3A4A5); fflip.push_back(-1);
        fids.push_back(40'hB1B2B3B4B5); fflip.push_back(-1);
        run_burst("alt", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
